fsm_input_conditioner: RTL and testbench
========================================

Name: fsm_input_conditioner

Overview:
- Upstream stage of the a/b-driven control FSM.
- Takes raw, unsynchronised a/b inputs from board pins or another clock domain, synchronises them, debounces each one independently, and presents two outputs per channel: a clean level and a single-cycle rising-edge pulse.
- The level and pulse outputs drive the FSM's a and b inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive mismatching samples required before the stable level changes. Legal range 1..255.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of the per-channel debounce counter. Derived; do not override.

Ports:
- clk      input   1  single clock; all state updates on posedge
- reset_n  input   1  synchronous, active-low reset
- a_raw    input   1  raw asynchronous channel A
- b_raw    input   1  raw asynchronous channel B
- a_lvl    output  1  debounced stable level of channel A
- b_lvl    output  1  debounced stable level of channel B
- a        output  1  one-cycle pulse on a_lvl 0->1
- b        output  1  one-cycle pulse on b_lvl 0->1

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset_n is synchronous and active-low: sampled only on posedge clk; 0 = reset.
- Reset values: every flop is 0. This covers both synchronizer stages, the stable levels, the counters and the pulse registers. Therefore a_lvl=b_lvl=a=b=0.
- Synchronizer: per channel, two-flop chain raw -> s1 -> s2. Only s2 feeds the debounce logic.
- Per-channel debounce, evaluated at every edge with reset_n=1:
  - s2 == lvl: cnt <= 0; lvl holds.
  - s2 != lvl and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != lvl and cnt == DEBOUNCE_CYCLES-1: lvl <= s2; cnt <= 0.
- Pulse generation:
  - The pulse is registered: it is set to 1 on the same edge that lvl changes 0->1, and cleared on the following edge.
  - Width is exactly 1 cycle.
  - No pulse on 1->0 transitions.
- Latency:
  - raw held high from the edge E0 onward (first edge to sample it) -> lvl and pulse become 1 after edge E0+DEBOUNCE_CYCLES+1.
  - Falling transitions: lvl drops to 0 after edge E0+DEBOUNCE_CYCLES+1 on the same rule.
- Glitch rejection: s2 deviating for fewer than DEBOUNCE_CYCLES consecutive edges returns cnt to 0 and leaves lvl unchanged. A partial count is never carried over.
- DEBOUNCE_CYCLES=1: lvl follows s2 with one edge of delay. The pulse rule is unchanged.
- Channel independence:
  - Channels A and B share no state.
  - Simultaneous qualifying transitions on both produce a and b in the same cycle.
- Reset mid-debounce:
  - Any in-flight count is discarded.
  - After release, a raw input still high runs the full debounce again from lvl=0. The pulse then fires normally.
- A pulse in flight when reset asserts is cleared on that reset edge.
- Outputs are driven directly from flops; no combinational path from raw to any output.

Optional Feature:
- Macro: GLITCH_COUNT_EN
- Defined:
  - Adds output port glitch_cnt [7:0].
  - Increments on every edge where, for some channel, cnt != 0 and s2 == lvl, i.e. an aborted debounce.
  - When both channels abort on the same edge, it increments by 2.
  - Saturates at 255.
  - Reset to 0 by reset_n.
- Not defined: no glitch_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4.
- Reset: hold reset_n=0 for 3 cycles with a_raw=b_raw=1 -> a_lvl=b_lvl=a=b=0 throughout; after release, a_lvl rises 6 edges after the first sampling edge.
- Clean rise: a_raw 0->1 held, first sampled at edge E0 -> a_lvl=1 and a=1 after E5; a=0 after E6; a_lvl stays 1; b, b_lvl stay 0.
- Glitch: a_raw high for exactly 3 cycles, then low -> a_lvl, a never assert; with GLITCH_COUNT_EN, glitch_cnt=1.
- Fall: from a_lvl=1, a_raw 1->0 held -> a_lvl=0 after E0+5; no pulse on a.
- Simultaneous: a_raw and b_raw rise on the same cycle -> a and b both pulse in the same cycle, one cycle wide.
- Reset mid-debounce: a_raw rises at E0, reset_n=0 at E3 for one cycle, a_raw held high -> no pulse before release; a pulses 6 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/fsm_input_conditioner.sv
// Two-flop synchroniser, per-channel debounce and registered rising-edge pulse for the a/b inputs.
// Optional macro GLITCH_COUNT_EN adds a saturating count of aborted debounce runs on glitch_cnt.
module fsm_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       a_lvl,
    output logic       b_lvl,
    output logic       a,
    output logic       b
`ifdef GLITCH_COUNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is channel A, bit 1 is channel B; the channels never interact.
    logic [1:0]       w_raw;
    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_lvl;
    logic [1:0]       r_pulse;
    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       w_mismatch;
    logic [1:0]       w_expire;

    assign w_raw = {b_raw, a_raw};

    always_comb begin
        w_mismatch = '0;
        w_expire   = '0;
        for (int i = 0; i < 2; i++) begin
            w_mismatch[i] = r_s2[i] != r_lvl[i];
            w_expire[i]   = w_mismatch[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_lvl   <= '0;
            r_pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < 2; i++) begin
                // Any matching sample drops a partial count; it never carries over.
                if (!w_mismatch[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_expire[i]) begin
                    r_lvl[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
                r_pulse[i] <= w_expire[i] && r_s2[i];
            end
        end
    end

    assign a_lvl = r_lvl[0];
    assign b_lvl = r_lvl[1];
    assign a     = r_pulse[0];
    assign b     = r_pulse[1];

`ifdef GLITCH_COUNT_EN
    logic [1:0] w_abort;
    logic [1:0] w_abort_sum;
    logic [7:0] r_glitch_cnt;

    function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, acc} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // An abort is a run of mismatches that ended before reaching the debounce length.
    always_comb begin
        w_abort = '0;
        for (int i = 0; i < 2; i++) begin
            w_abort[i] = !w_mismatch[i] && (r_cnt[i] != '0);
        end
        w_abort_sum = {1'b0, w_abort[0]} + {1'b0, w_abort[1]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_glitch_cnt <= '0;
        end else begin
            r_glitch_cnt <= sat_add8(r_glitch_cnt, w_abort_sum);
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Directed bench for fsm_input_conditioner: a window-based reference model checked every cycle,
// plus hand-computed latency/pulse expectations from the test plan.
module tb_fsm_input_conditioner;

    localparam int DC = 4;

    logic clk;
    logic reset_n;
    logic a_raw;
    logic b_raw;
    logic a_lvl;
    logic b_lvl;
    logic a;
    logic b;
`ifdef GLITCH_COUNT_EN
    logic [7:0] glitch_cnt;
`endif

    int checks;
    int failures;
    bit cmp_en;

    fsm_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .a_raw   (a_raw),
        .b_raw   (b_raw),
        .a_lvl   (a_lvl),
        .b_lvl   (b_lvl),
        .a       (a),
        .b       (b)
`ifdef GLITCH_COUNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {7'b0, act}, {7'b0, exp});
    endtask

    // Model: a level flips once the last DC synchronised samples all disagree with it.
    bit m_sy1 [2];
    bit m_sy2 [2];
    bit m_lvl [2];
    bit m_pulse [2];
    bit m_hist [2][DC];
    int m_glitch;

    initial begin : model
        bit raw [2];
        bit s2;
        bit prev;
        bit flip;
        int aborts;
        m_glitch = 0;
        forever begin
            @(posedge clk);
            raw[0] = a_raw;
            raw[1] = b_raw;
            if (!reset_n) begin
                for (int c = 0; c < 2; c++) begin
                    m_sy1[c] = 0;
                    m_sy2[c] = 0;
                    m_lvl[c] = 0;
                    m_pulse[c] = 0;
                    for (int k = 0; k < DC; k++) m_hist[c][k] = 0;
                end
                m_glitch = 0;
            end else begin
                aborts = 0;
                for (int c = 0; c < 2; c++) begin
                    s2 = m_sy2[c];
                    prev = m_hist[c][0];
                    for (int k = DC - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                    m_hist[c][0] = s2;
                    flip = 1;
                    for (int k = 0; k < DC; k++) if (m_hist[c][k] == m_lvl[c]) flip = 0;
                    if (s2 == m_lvl[c] && prev != m_lvl[c]) aborts++;
                    m_pulse[c] = flip && !m_lvl[c];
                    if (flip) m_lvl[c] = !m_lvl[c];
                    m_sy2[c] = m_sy1[c];
                    m_sy1[c] = raw[c];
                end
                m_glitch = (m_glitch + aborts > 255) ? 255 : m_glitch + aborts;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk1("model_a_lvl", a_lvl, m_lvl[0]);
                chk1("model_b_lvl", b_lvl, m_lvl[1]);
                chk1("model_a", a, m_pulse[0]);
                chk1("model_b", b, m_pulse[1]);
`ifdef GLITCH_COUNT_EN
                chk("model_glitch_cnt", glitch_cnt, 8'(m_glitch));
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        logic [15:0] pat_a [3];
        logic [15:0] pat_b [3];
`ifdef GLITCH_COUNT_EN
        logic [7:0] g0;
`endif
        checks   = 0;
        failures = 0;
        cmp_en   = 0;
        reset_n  = 1'b0;
        a_raw    = 1'b1;
        b_raw    = 1'b1;
        pat_a[0] = 16'b0110_1111_1011_0000;
        pat_b[0] = 16'b1111_0111_0000_1000;
        pat_a[1] = 16'b1010_1010_1111_1111;
        pat_b[1] = 16'b0001_1100_0111_1000;
        pat_a[2] = 16'b0000_1110_0000_1111;
        pat_b[2] = 16'b1111_1111_0101_0000;

        // Reset held three cycles with raw inputs high.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            cmp_en = 1;
            chk1("rst_a_lvl", a_lvl, 1'b0);
            chk1("rst_b_lvl", b_lvl, 1'b0);
            chk1("rst_a", a, 1'b0);
            chk1("rst_b", b, 1'b0);
        end
        reset_n = 1'b1;
        tick(5);
        chk1("post_rst_a_lvl_E4", a_lvl, 1'b0);
        tick(1);
        chk1("post_rst_a_lvl_E5", a_lvl, 1'b1);
        chk1("post_rst_a_E5", a, 1'b1);
        chk1("post_rst_b_E5", b, 1'b1);
        tick(1);
        chk1("post_rst_a_E6", a, 1'b0);
        chk1("post_rst_a_lvl_E6", a_lvl, 1'b1);

        // Fall on both channels: no pulse.
        a_raw = 1'b0;
        b_raw = 1'b0;
        tick(5);
        chk1("fall_a_lvl_E4", a_lvl, 1'b1);
        tick(1);
        chk1("fall_a_lvl_E5", a_lvl, 1'b0);
        chk1("fall_a_E5", a, 1'b0);
        tick(4);

        // Clean rise on A only.
        a_raw = 1'b1;
        tick(5);
        chk1("rise_a_lvl_E4", a_lvl, 1'b0);
        tick(1);
        chk1("rise_a_lvl_E5", a_lvl, 1'b1);
        chk1("rise_a_E5", a, 1'b1);
        chk1("rise_b_lvl_E5", b_lvl, 1'b0);
        chk1("rise_b_E5", b, 1'b0);
        tick(1);
        chk1("rise_a_E6", a, 1'b0);
        chk1("rise_a_lvl_E6", a_lvl, 1'b1);
        a_raw = 1'b0;
        tick(8);

        // Three-cycle glitch is rejected.
`ifdef GLITCH_COUNT_EN
        g0 = glitch_cnt;
`endif
        a_raw = 1'b1;
        tick(3);
        a_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk1("glitch_a_lvl", a_lvl, 1'b0);
            chk1("glitch_a", a, 1'b0);
        end
`ifdef GLITCH_COUNT_EN
        chk("glitch_cnt_delta", glitch_cnt, g0 + 8'd1);
`endif

        // Simultaneous rise.
        a_raw = 1'b1;
        b_raw = 1'b1;
        tick(6);
        chk1("sim_a_E5", a, 1'b1);
        chk1("sim_b_E5", b, 1'b1);
        tick(1);
        chk1("sim_a_E6", a, 1'b0);
        chk1("sim_b_E6", b, 1'b0);
        chk1("sim_b_lvl_E6", b_lvl, 1'b1);
        a_raw = 1'b0;
        b_raw = 1'b0;
        tick(8);

        // Reset lands at E3 of a debounce run.
        a_raw = 1'b1;
        tick(3);
        reset_n = 1'b0;
        tick(1);
        chk1("mid_rst_a", a, 1'b0);
        chk1("mid_rst_a_lvl", a_lvl, 1'b0);
        reset_n = 1'b1;
        tick(5);
        chk1("mid_rel_a_E4", a, 1'b0);
        chk1("mid_rel_a_lvl_E4", a_lvl, 1'b0);
        tick(1);
        chk1("mid_rel_a_E5", a, 1'b1);
        chk1("mid_rel_a_lvl_E5", a_lvl, 1'b1);
        tick(1);
        chk1("mid_rel_a_E6", a, 1'b0);
        a_raw = 1'b0;
        tick(8);

        // Reset on the edge after a pulse is set clears it.
        b_raw = 1'b1;
        tick(6);
        chk1("inflight_b_set", b, 1'b1);
        reset_n = 1'b0;
        tick(1);
        chk1("inflight_b_cleared", b, 1'b0);
        chk1("inflight_b_lvl_cleared", b_lvl, 1'b0);
        reset_n = 1'b1;
        b_raw = 1'b0;
        tick(8);

        // Bouncing sequences, checked against the model every cycle.
        for (int p = 0; p < 3; p++) begin
            for (int i = 15; i >= 0; i--) begin
                a_raw = pat_a[p][i];
                b_raw = pat_b[p][i];
                tick(1);
            end
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
